// File: rtl/fetch_unit.sv
// fetch_unit: issues pc_i to a 1-cycle instruction memory and buffers returned words for decode.
module fetch_unit #(
  parameter int INSTR_W = 9,
  parameter int DEPTH = 2,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [7:0]         pc_i,
  output logic               pc_hold_o,
  output logic               imem_req_o,
  output logic [7:0]         imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [7:0]         instr_pc_o,
  output logic               halted_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = DEPTH[CW:0];
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic inflight;
  logic [7:0] pc_q;
  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [7:0] pcs_q [DEPTH];
  logic pop, halt_accept, issue, push;
  logic [CW:0] need;
  // Credit: entries held plus the word still in flight must leave room for this issue.
  always_comb begin
    pop = instr_valid_o & instr_ready_i;
    halt_accept = (state == RUN) & pop & (instr_o[INSTR_W-1 -: 3] == HALT_OP) & ~flush_i;
    need = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue = (state == RUN) & ~flush_i & ~halt_accept & (need < LIM);
    push = inflight & ~flush_i & ~halt_accept;
  end
  assign imem_req_o = issue;
  assign imem_addr_o = pc_i;
  assign pc_hold_o = ~issue;
  assign instr_valid_o = count != '0;
  assign instr_o = data_q[rd_ptr];
  assign instr_pc_o = pcs_q[rd_ptr];
  assign halted_o = state == HALTED;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= 1'b0;
      pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) pc_q <= pc_i;
      if (flush_i) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else if (halt_accept) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        state <= HALTED;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= imem_data_i;
          pcs_q[wr_ptr] <= pc_q;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        if (start_i && state != RUN) state <= RUN;
      end
    end
endmodule
